bpsk_demodulator: RTL and testbench

BPSK_DEMODULATOR -- requirements
Module: bpsk_demodulator

---
 rtl/bpsk_demodulator.sv | 202 ++++++++++++++++++++
 tb/tb_bpsk_demodulator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_demodulator.sv
// bpsk_demodulator
//
// Recovers framed data from a BPSK line. On that line the carrier is clk_in/2 and is XORed with
// the data during a burst. Between bursts the line is held at 0. A free-running local carrier
// removes the modulation. Each bit period is integrated over a guarded window and decided by
// majority vote. The first 32-bit word must equal SYNC_WORD or its complement. The complement
// case means the local carrier runs in anti-phase, and the data is inverted to compensate.
// After lock, WORDS-1 further words are delivered, and then the frame closes.
//
// Ports
//   clk_in        single system clock (7.68 MHz nominal), rising edge
//   rst           synchronous, active-high reset
//   bpsk_in       BPSK line input (asynchronous to nothing, but double-registered)
//   bit_out       polarity-corrected decided bit, valid with bit_valid
//   bit_valid     one-cycle pulse per decided bit after lock
//   word_out      last completed word, MSB = first received bit
//   word_valid    one-cycle pulse when word_out updates
//   frame_lock    high from sync match until the frame ends
//   polarity_inv  high when lock was achieved on the complemented sync word
//   frame_done    one-cycle pulse the cycle after the last word_valid
//   sync_err      one-cycle pulse when the first word matches neither sync form
module bpsk_demodulator #(
    parameter int unsigned BIT_LEN   = 544,
    parameter int unsigned GUARD     = 16,
    parameter int unsigned QUIET_MIN = 64,
    parameter logic [31:0] SYNC_WORD = 32'h0AEC7CD2,
    parameter int unsigned WORDS     = 4
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        bpsk_in,
    output logic        bit_out,
    output logic        bit_valid,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic        frame_lock,
    output logic        polarity_inv,
    output logic        frame_done,
    output logic        sync_err
);

    localparam int unsigned IdxW    = $clog2(BIT_LEN + 1);
    localparam int unsigned CntW    = $clog2(BIT_LEN + 1);
    localparam int unsigned QuietW  = $clog2(QUIET_MIN + 1);
    localparam int unsigned WordW   = $clog2(WORDS + 1);
    localparam int unsigned WinHalf = (BIT_LEN - 2 * GUARD) / 2;

    typedef enum logic [1:0] {StQuiet, StArmed, StAcq, StLocked} state_e;

    state_e              state_q;
    logic                s1_q;
    logic                s_q;
    logic                s_prev_q;
    logic                c_q;
    logic [QuietW-1:0]   quiet_q;
    logic [IdxW-1:0]     idx_q;
    logic [CntW-1:0]     ones_q;
    logic [4:0]          bit_idx_q;
    logic [WordW-1:0]    word_cnt_q;
    logic                last_q;
    logic [31:0]         shift_q;

    logic                d;
    logic                in_win;
    logic                bit_end;
    logic                word_end;
    logic                bit_dec;
    logic [CntW-1:0]     ones_next;
    logic [31:0]         shift_next;

    // Datapath helpers: carrier wipe-off, integration window and the bit decision.
    // The decision uses ones_next so a window reaching the last sample (GUARD = 0)
    // still counts that sample.
    always_comb begin
        d          = s_q ^ c_q;
        in_win     = (idx_q >= IdxW'(GUARD)) && (idx_q <= IdxW'(BIT_LEN - GUARD - 1));
        ones_next  = ones_q + CntW'(in_win & d);
        bit_end    = (idx_q == IdxW'(BIT_LEN - 1));
        word_end   = (bit_idx_q == 5'd31);
        bit_dec    = (ones_next > CntW'(WinHalf));
        shift_next = (shift_q << 1) | 32'(bit_dec);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= StQuiet;
            s1_q         <= 1'b0;
            s_q          <= 1'b0;
            s_prev_q     <= 1'b0;
            c_q          <= 1'b0;
            quiet_q      <= '0;
            idx_q        <= '0;
            ones_q       <= '0;
            bit_idx_q    <= '0;
            word_cnt_q   <= '0;
            last_q       <= 1'b0;
            shift_q      <= '0;
            bit_out      <= 1'b0;
            bit_valid    <= 1'b0;
            word_out     <= '0;
            word_valid   <= 1'b0;
            frame_lock   <= 1'b0;
            polarity_inv <= 1'b0;
            frame_done   <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            s1_q       <= bpsk_in;
            s_q        <= s1_q;
            s_prev_q   <= s_q;
            c_q        <= ~c_q;
            bit_valid  <= 1'b0;
            word_valid <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;

            unique case (state_q)
                StQuiet: begin
                    // A burst toggles the line at least every other cycle, so a long
                    // constant run can only be idle line.
                    if (s_q == s_prev_q) begin
                        if (quiet_q == QuietW'(QUIET_MIN - 1)) begin
                            state_q <= StArmed;
                        end else begin
                            quiet_q <= quiet_q + QuietW'(1);
                        end
                    end else begin
                        quiet_q <= '0;
                    end
                end

                StArmed: begin
                    // The first edge starts bit timing. From here on, timing runs free and
                    // ignores later line transitions.
                    if (s_q != s_prev_q) begin
                        state_q   <= StAcq;
                        idx_q     <= '0;
                        ones_q    <= '0;
                        bit_idx_q <= '0;
                        shift_q   <= '0;
                    end
                end

                StAcq: begin
                    if (bit_end) begin
                        idx_q     <= '0;
                        ones_q    <= '0;
                        shift_q   <= shift_next;
                        bit_idx_q <= bit_idx_q + 5'd1;
                        if (word_end) begin
                            if (shift_next == SYNC_WORD || shift_next == ~SYNC_WORD) begin
                                state_q      <= StLocked;
                                frame_lock   <= 1'b1;
                                polarity_inv <= (shift_next == ~SYNC_WORD);
                                word_out     <= SYNC_WORD;
                                word_valid   <= 1'b1;
                                word_cnt_q   <= WordW'(1);
                                last_q       <= (WORDS == 1);
                            end else begin
                                sync_err <= 1'b1;
                                state_q  <= StQuiet;
                                quiet_q  <= '0;
                            end
                        end
                    end else begin
                        idx_q  <= idx_q + IdxW'(1);
                        ones_q <= ones_next;
                    end
                end

                StLocked: begin
                    if (last_q) begin
                        // The cycle after the final word_valid closes the frame.
                        frame_done <= 1'b1;
                        frame_lock <= 1'b0;
                        last_q     <= 1'b0;
                        state_q    <= StQuiet;
                        quiet_q    <= '0;
                    end else if (bit_end) begin
                        idx_q     <= '0;
                        ones_q    <= '0;
                        shift_q   <= shift_next;
                        bit_idx_q <= bit_idx_q + 5'd1;
                        bit_out   <= bit_dec ^ polarity_inv;
                        bit_valid <= 1'b1;
                        if (word_end) begin
                            word_out   <= shift_next ^ {32{polarity_inv}};
                            word_valid <= 1'b1;
                            word_cnt_q <= word_cnt_q + WordW'(1);
                            if (word_cnt_q == WordW'(WORDS - 1)) begin
                                last_q <= 1'b1;
                            end
                        end
                    end else begin
                        idx_q  <= idx_q + IdxW'(1);
                        ones_q <= ones_next;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bpsk_demodulator.sv
// tb_bpsk_demodulator
//
// Directed bench for bpsk_demodulator. It uses a shortened bit period so that all scenarios fit
// in a short run. Stimulus is generated per sample from a model of the free-running local
// carrier. Expected words, bits, pulse counts and polarity are derived from the transmitted
// frame contents.
module tb_bpsk_demodulator;

    localparam int unsigned BL   = 32;
    localparam int unsigned GD   = 10;
    localparam int unsigned QM   = 16;
    localparam int unsigned NW   = 4;
    localparam logic [31:0] SYNC = 32'h0AEC7CD2;

    logic        clk = 1'b0;
    logic        rst;
    logic        bpsk_in;
    logic        bit_out;
    logic        bit_valid;
    logic [31:0] word_out;
    logic        word_valid;
    logic        frame_lock;
    logic        polarity_inv;
    logic        frame_done;
    logic        sync_err;

    bpsk_demodulator #(
        .BIT_LEN  (BL),
        .GUARD    (GD),
        .QUIET_MIN(QM),
        .SYNC_WORD(SYNC),
        .WORDS    (NW)
    ) dut (
        .clk_in      (clk),
        .rst         (rst),
        .bpsk_in     (bpsk_in),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .frame_lock  (frame_lock),
        .polarity_inv(polarity_inv),
        .frame_done  (frame_done),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic        c_mod = 1'b0;  // local carrier value after the most recent rising edge
    logic [31:0] fw [4];        // words of the burst being transmitted
    logic [31:0] word_q [$];
    logic        bit_q [$];
    int          n_done = 0;
    int          n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Output monitor, away from the active edge.
    always @(negedge clk) begin
        if (word_valid) word_q.push_back(word_out);
        if (bit_valid) bit_q.push_back(bit_out);
        if (frame_done) n_done++;
        if (sync_err) n_err++;
    end

    // One sample, captured at the next rising edge. The transmit carrier is the local carrier
    // after that edge, XOR inv. Demodulation pairs the sample with the following local carrier
    // value, so the received data comes out inverted when inv = 0.
    task automatic drive(input logic r, input logic active, input logic dat, input logic inv);
        logic c_next;
        @(negedge clk);
        c_next  = r ? 1'b0 : ~c_mod;
        rst     = r;
        bpsk_in = active ? (c_next ^ inv ^ dat) : 1'b0;
        c_mod   = c_next;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic int jit_at(input int k, input logic en);
        if (!en || k == 0 || k >= 128) return 0;
        return ((k * 5) % 17) - 8;
    endfunction

    task automatic burst(input logic inv, input logic jit, input int rst_bits,
                         output logic lock_mid, output logic [31:0] snap_word,
                         output logic snap_pol);
        int   len;
        logic dat;
        lock_mid  = 1'b0;
        snap_word = '0;
        snap_pol  = 1'b0;
        for (int b = 0; b < 128; b++) begin
            len = int'(BL) + jit_at(b + 1, jit) - jit_at(b, jit);
            dat = fw[b / 32][31 - (b % 32)];
            for (int j = 0; j < len; j++) begin
                drive(b < rst_bits, 1'b1, dat, inv);
                if (j == 0 && b == 64) lock_mid = frame_lock;
                if (j == 0 && b == 20) begin
                    snap_word = word_out;
                    snap_pol  = polarity_inv;
                end
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic locked, input logic pol_exp,
                               input int err_exp, input logic lock_mid);
        int nw;
        int nb;
        nw = locked ? int'(NW) : 0;
        nb = locked ? int'(NW - 1) * 32 : 0;
        check_val({tag, "_nwords"}, 32'(word_q.size()), 32'(nw));
        for (int i = 0; i < nw && i < word_q.size(); i++)
            check_val($sformatf("%s_w%0d", tag, i), word_q[i], fw[i]);
        check_val({tag, "_nbits"}, 32'(bit_q.size()), 32'(nb));
        for (int i = 0; i < nb && i < bit_q.size(); i++)
            check_val($sformatf("%s_b%0d", tag, i), 32'(bit_q[i]),
                      32'(fw[1 + i / 32][31 - (i % 32)]));
        check_val({tag, "_done"}, 32'(n_done), locked ? 32'd1 : 32'd0);
        check_val({tag, "_serr"}, 32'(n_err), 32'(err_exp));
        check_val({tag, "_lock_mid"}, 32'(lock_mid), 32'(locked));
        check_val({tag, "_lock_end"}, 32'(frame_lock), 32'd0);
        if (locked) check_val({tag, "_pol"}, 32'(polarity_inv), 32'(pol_exp));
        word_q.delete();
        bit_q.delete();
        n_done = 0;
        n_err  = 0;
    endtask

    initial begin
        logic        lm;
        logic [31:0] sw;
        logic        sp;
        rst     = 1'b1;
        bpsk_in = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("rst_word", word_out, 32'h0);
        check_val("rst_flags", {25'd0, bit_out, bit_valid, word_valid, frame_lock, polarity_inv,
                                frame_done, sync_err}, 32'h0);
        idle(200);

        // Nominal burst, transmit carrier in anti-phase with the local carrier model.
        fw = '{SYNC, SYNC, SYNC, SYNC};
        burst(1'b0, 1'b0, 0, lm, sw, sp);
        idle(40);
        check_frame("a", 1'b1, 1'b1, 0, lm);

        // Carrier inverted: same words, opposite polarity flag.
        burst(1'b1, 1'b0, 0, lm, sw, sp);
        idle(40);
        check_frame("b", 1'b1, 1'b0, 0, lm);

        // Bad sync word.
        fw = '{32'h12345678, SYNC, SYNC, SYNC};
        burst(1'b0, 1'b0, 0, lm, sw, sp);
        idle(40);
        check_frame("e", 1'b0, 1'b0, 1, lm);

        // Jittered data edges, start offsets 0 and 1.
        fw = '{SYNC, 32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF};
        burst(1'b1, 1'b1, 0, lm, sw, sp);
        idle(40);
        check_frame("j0", 1'b1, 1'b0, 0, lm);
        idle(1);
        fw = '{SYNC, 32'h5A5AA5A5, 32'h13579BDF, 32'h80000001};
        burst(1'b0, 1'b1, 0, lm, sw, sp);
        idle(40);
        check_frame("j1", 1'b1, 1'b1, 0, lm);

        // Reset held for the first 40 bits, then released with the burst still running.
        fw = '{SYNC, SYNC, SYNC, SYNC};
        burst(1'b0, 1'b0, 40, lm, sw, sp);
        check_val("r_snap_word", sw, 32'h0);
        check_val("r_snap_pol", 32'(sp), 32'd0);
        idle(40);
        check_frame("r", 1'b0, 1'b0, 0, lm);
        check_val("r_word_after", word_out, 32'h0);
        idle(128 * BL - 40);
        fw = '{SYNC, 32'h0F0F0F0F, 32'hC3C3C3C3, 32'h76543210};
        burst(1'b0, 1'b0, 0, lm, sw, sp);
        idle(40);
        check_frame("r2", 1'b1, 1'b1, 0, lm);

        // Two frames with a 128-bit idle gap.
        fw = '{SYNC, 32'hA5A5A5A5, 32'h01234567, 32'hFEDCBA98};
        burst(1'b1, 1'b0, 0, lm, sw, sp);
        idle(40);
        check_frame("bb1", 1'b1, 1'b0, 0, lm);
        idle(64 * BL - 40);
        check_val("bb_gap_lock", 32'(frame_lock), 32'd0);
        idle(64 * BL);
        fw = '{SYNC, 32'h3C3C3C3C, 32'h89ABCDEF, 32'h55555555};
        burst(1'b0, 1'b0, 0, lm, sw, sp);
        idle(40);
        check_frame("bb2", 1'b1, 1'b1, 0, lm);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
